// File: rtl/nvram_upload_reader_if.sv
// Bundles the HPS ioctl upload signals, the RAM read port and the dirty/save signals.
// The slave modport is the reader's side. The master modport is the HPS/core/RAM side.
interface nvram_upload_reader_if #(
  parameter int ADDR_W = 10
);
  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic              ioctl_upload_req;
  logic              save_trigger;
  logic              core_we;
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_gnt;
  logic [7:0]        ram_q;
  logic              dirty;

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
    input  save_trigger, core_we, ram_gnt, ram_q,
    output ioctl_din, ioctl_wait, ioctl_upload_req, ram_rd, ram_addr, dirty
  );

  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
    output save_trigger, core_we, ram_gnt, ram_q,
    input  ioctl_din, ioctl_wait, ioctl_upload_req, ram_rd, ram_addr, dirty
  );
endinterface

// File: rtl/nvram_upload_reader.sv
// Answers HPS ioctl upload byte reads from a core NVRAM read port.
// ioctl_wait stays high until the byte is on ioctl_din.
// Tracks core writes and requests an upload when the RAM is dirty.
module nvram_upload_reader #(
  parameter int          ADDR_W       = 10,
  parameter int          RAM_LATENCY  = 2,
  parameter logic [7:0]  UPLOAD_INDEX = 8'd2,
  parameter logic [7:0]  FILL_BYTE    = 8'hFF
) (
  input  logic clk_sys,
  input  logic reset,
  nvram_upload_reader_if.slave bus
);

  localparam logic [2:0] LAT = 3'(RAM_LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [7:0]        din, din_nxt;
  logic              wait_r, wait_nxt;
  logic              ram_rd, ram_rd_nxt;
  logic [ADDR_W-1:0] ram_addr, ram_addr_nxt;
  logic              dirty, upload_req;
  logic              upload_q, trig_q;

  // Reads for other indices, or outside an upload session, are ignored.
  // The range test covers every address bit, so high addresses never wrap into the RAM.
  logic rd_ok, in_range, upload_fall, trig_rise;
  assign rd_ok       = bus.ioctl_rd && bus.ioctl_upload && (bus.ioctl_index == UPLOAD_INDEX);
  assign in_range    = (bus.ioctl_addr[24:ADDR_W] == '0);
  assign upload_fall = upload_q && !bus.ioctl_upload && (bus.ioctl_index == UPLOAD_INDEX);
  assign trig_rise   = bus.save_trigger && !trig_q;

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic. A drop of ioctl_upload mid-transfer aborts the transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (rd_ok && in_range) state_nxt = S_REQ;
      S_REQ: begin
        if (!bus.ioctl_upload) state_nxt = S_IDLE;
        else if (bus.ram_gnt)  state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!bus.ioctl_upload) state_nxt = S_IDLE;
        else if (cnt == '0)    state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and the latency counter.
  always_comb begin
    din_nxt      = din;
    wait_nxt     = wait_r;
    ram_rd_nxt   = ram_rd;
    ram_addr_nxt = ram_addr;
    cnt_nxt      = cnt;
    case (state)
      S_IDLE: begin
        wait_nxt   = 1'b0;
        ram_rd_nxt = 1'b0;
        if (rd_ok) begin
          wait_nxt = 1'b1;
          if (in_range) begin
            ram_addr_nxt = bus.ioctl_addr[ADDR_W-1:0];
            ram_rd_nxt   = 1'b1;
          end else begin
            din_nxt = FILL_BYTE;
          end
        end
      end
      S_REQ: begin
        if (!bus.ioctl_upload) begin
          ram_rd_nxt = 1'b0;
          wait_nxt   = 1'b0;
        end else if (bus.ram_gnt) begin
          ram_rd_nxt = 1'b0;
          cnt_nxt    = LAT;
        end
      end
      S_WAIT: begin
        if (!bus.ioctl_upload) begin
          wait_nxt = 1'b0;
        end else if (cnt == '0) begin
          din_nxt  = bus.ram_q;
          wait_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      default: begin
        wait_nxt   = 1'b0;
        ram_rd_nxt = 1'b0;
      end
    endcase
  end

  // Output and counter registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      din      <= '0;
      wait_r   <= 1'b0;
      ram_rd   <= 1'b0;
      ram_addr <= '0;
      cnt      <= '0;
    end else begin
      din      <= din_nxt;
      wait_r   <= wait_nxt;
      ram_rd   <= ram_rd_nxt;
      ram_addr <= ram_addr_nxt;
      cnt      <= cnt_nxt;
    end
  end

  // Dirty tracking. A core write wins over the end-of-upload clear.
  // The edge registers detect the end of an upload and a new save request.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dirty      <= 1'b0;
      upload_q   <= 1'b0;
      trig_q     <= 1'b0;
      upload_req <= 1'b0;
    end else begin
      upload_q   <= bus.ioctl_upload;
      trig_q     <= bus.save_trigger;
      upload_req <= trig_rise && dirty && !bus.ioctl_upload;
      if (bus.core_we)      dirty <= 1'b1;
      else if (upload_fall) dirty <= 1'b0;
    end
  end

  assign bus.ioctl_din        = din;
  assign bus.ioctl_wait       = wait_r;
  assign bus.ram_rd           = ram_rd;
  assign bus.ram_addr         = ram_addr;
  assign bus.dirty            = dirty;
  assign bus.ioctl_upload_req = upload_req;

endmodule

// File: tb/tb_nvram_upload_reader.sv
// Directed bench for nvram_upload_reader. A small RAM model has a 2-cycle read latency.
module tb_nvram_upload_reader;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  nvram_upload_reader_if #(.ADDR_W(10)) bus ();

  nvram_upload_reader #(
    .ADDR_W(10), .RAM_LATENCY(2), .UPLOAD_INDEX(8'd2), .FILL_BYTE(8'hFF)
  ) dut (
    .clk_sys (clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  // The RAM model returns data 2 clocks after an accepted read.
  // ram_q holds 0xEE until the first read, so an early capture shows up as a wrong byte.
  logic [7:0] mem [1024];
  logic       v1 = 1'b0, v2 = 1'b0;
  logic [9:0] a1 = '0, a2 = '0;
  logic [7:0] q_r = 8'hEE;
  always @(posedge clk) begin
    v1 <= bus.ram_rd && bus.ram_gnt;
    a1 <= bus.ram_addr;
    v2 <= v1;
    a2 <= a1;
    if (v2) q_r <= mem[a2];
  end
  assign bus.ram_q = q_r;

  // Issues one read and returns the wait cycle count, the ram_rd cycle count and whether ram_addr stayed correct.
  // The grant is held low for gnt_delay cycles.
  task automatic do_read(input logic [24:0] addr, input int gnt_delay,
                         output int wcnt, output int rcnt, output bit addr_ok, output bit timeout);
    wcnt = 0; rcnt = 0; addr_ok = 1'b1; timeout = 1'b1;
    @(negedge clk);
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = addr; bus.ram_gnt = (gnt_delay == 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.ioctl_rd = 1'b0;
      if (bus.ioctl_wait) wcnt++;
      if (bus.ram_rd) begin
        rcnt++;
        if (bus.ram_addr !== addr[9:0]) addr_ok = 1'b0;
      end
      bus.ram_gnt = (i >= gnt_delay);
      if (!bus.ioctl_wait) begin timeout = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.ioctl_din !== 8'h00) begin errors++; $display("FAIL reset_din got=%h exp=00", bus.ioctl_din); end
    checks++; if (bus.ioctl_wait !== 1'b0) begin errors++; $display("FAIL reset_wait got=%b exp=0", bus.ioctl_wait); end
    checks++; if (bus.ram_rd !== 1'b0) begin errors++; $display("FAIL reset_ram_rd got=%b exp=0", bus.ram_rd); end
    checks++; if (bus.ram_addr !== 10'h000) begin errors++; $display("FAIL reset_ram_addr got=%h exp=000", bus.ram_addr); end
    checks++; if (bus.dirty !== 1'b0) begin errors++; $display("FAIL reset_dirty got=%b exp=0", bus.dirty); end
    checks++; if (bus.ioctl_upload_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", bus.ioctl_upload_req); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_basic();
    int w, r; bit ok, to;
    bus.ioctl_upload = 1'b1; bus.ioctl_index = 8'd2;
    do_read(25'h005, 0, w, r, ok, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout wait never fell"); end
    checks++; if (w != 4) begin errors++; $display("FAIL basic_wait_cycles got=%0d exp=4", w); end
    checks++; if (r != 1) begin errors++; $display("FAIL basic_ram_rd_cycles got=%0d exp=1", r); end
    checks++; if (!ok) begin errors++; $display("FAIL basic_ram_addr got=bad exp=005"); end
    checks++; if (bus.ioctl_din !== 8'h3C) begin errors++; $display("FAIL basic_din got=%h exp=3c", bus.ioctl_din); end
  endtask

  task automatic test_grant_delay();
    int w, r; bit ok, to;
    do_read(25'h006, 5, w, r, ok, to);
    checks++; if (to) begin errors++; $display("FAIL gnt_timeout wait never fell"); end
    checks++; if (r != 6) begin errors++; $display("FAIL gnt_ram_rd_cycles got=%0d exp=6", r); end
    checks++; if (w != 9) begin errors++; $display("FAIL gnt_wait_cycles got=%0d exp=9", w); end
    checks++; if (!ok) begin errors++; $display("FAIL gnt_ram_addr got=bad exp=006"); end
    checks++; if (bus.ioctl_din !== 8'h5A) begin errors++; $display("FAIL gnt_din got=%h exp=5a", bus.ioctl_din); end
  endtask

  task automatic test_out_of_range();
    logic [24:0] addrs [2];
    addrs[0] = 25'h0000400; addrs[1] = 25'h1000005;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.ioctl_rd = 1'b1; bus.ioctl_addr = addrs[k];
      @(negedge clk);
      bus.ioctl_rd = 1'b0;
      checks++; if (bus.ioctl_wait !== 1'b1) begin errors++; $display("FAIL oor_wait_hi[%0d] got=%b exp=1", k, bus.ioctl_wait); end
      checks++; if (bus.ram_rd !== 1'b0) begin errors++; $display("FAIL oor_ram_rd[%0d] got=%b exp=0", k, bus.ram_rd); end
      checks++; if (bus.ioctl_din !== 8'hFF) begin errors++; $display("FAIL oor_din[%0d] got=%h exp=ff", k, bus.ioctl_din); end
      @(negedge clk);
      checks++; if (bus.ioctl_wait !== 1'b0 || bus.ram_rd !== 1'b0) begin
        errors++; $display("FAIL oor_wait_lo[%0d] got wait=%b ram_rd=%b exp=0/0", k, bus.ioctl_wait, bus.ram_rd);
      end
    end
  endtask

  task automatic test_wrong_index();
    bus.ioctl_index = 8'd0;
    @(negedge clk);
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'h005;
    @(negedge clk);
    bus.ioctl_rd = 1'b0;
    checks++; if (bus.ioctl_wait !== 1'b0 || bus.ram_rd !== 1'b0) begin
      errors++; $display("FAIL idx_wait got wait=%b ram_rd=%b exp=0/0", bus.ioctl_wait, bus.ram_rd);
    end
    repeat (5) @(negedge clk);
    checks++; if (bus.ioctl_din !== 8'hFF) begin errors++; $display("FAIL idx_din got=%h exp=ff", bus.ioctl_din); end
    bus.ioctl_index = 8'd2;
  endtask

  task automatic test_dirty_req();
    bit seen;
    // Ending the upload session at index 2 clears dirty.
    @(negedge clk); bus.ioctl_upload = 1'b0;
    @(negedge clk);
    checks++; if (bus.dirty !== 1'b0) begin errors++; $display("FAIL dirty_init got=%b exp=0", bus.dirty); end
    bus.core_we = 1'b1;
    @(negedge clk); bus.core_we = 1'b0;
    checks++; if (bus.dirty !== 1'b1) begin errors++; $display("FAIL dirty_set got=%b exp=1", bus.dirty); end
    bus.save_trigger = 1'b1;
    @(negedge clk);
    checks++; if (bus.ioctl_upload_req !== 1'b1) begin errors++; $display("FAIL req_pulse got=%b exp=1", bus.ioctl_upload_req); end
    @(negedge clk);
    checks++; if (bus.ioctl_upload_req !== 1'b0) begin errors++; $display("FAIL req_one_cycle got=%b exp=0", bus.ioctl_upload_req); end
    bus.save_trigger = 1'b0;
    // A save request during an upload is not served, even while dirty.
    @(negedge clk); bus.ioctl_upload = 1'b1; bus.save_trigger = 1'b1;
    seen = 1'b0;
    repeat (2) begin @(negedge clk); if (bus.ioctl_upload_req) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL req_during_upload got=1 exp=0"); end
    bus.save_trigger = 1'b0; bus.ioctl_upload = 1'b0;
    @(negedge clk);
    checks++; if (bus.dirty !== 1'b0) begin errors++; $display("FAIL dirty_clear got=%b exp=0", bus.dirty); end
    bus.save_trigger = 1'b1;
    seen = 1'b0;
    repeat (2) begin @(negedge clk); if (bus.ioctl_upload_req) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL req_clean got=1 exp=0"); end
    bus.save_trigger = 1'b0;
    // A core write in the same cycle as the end of the upload keeps dirty set.
    bus.ioctl_upload = 1'b1;
    @(negedge clk); bus.ioctl_upload = 1'b0; bus.core_we = 1'b1;
    @(negedge clk); bus.core_we = 1'b0;
    @(negedge clk);
    checks++; if (bus.dirty !== 1'b1) begin errors++; $display("FAIL dirty_set_wins got=%b exp=1", bus.dirty); end
  endtask

  task automatic test_abort();
    int w, r; bit ok, to;
    logic [7:0] din_before;
    bus.ioctl_upload = 1'b1; bus.ram_gnt = 1'b1;
    @(negedge clk);
    din_before = bus.ioctl_din;
    bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'h007;
    @(negedge clk); bus.ioctl_rd = 1'b0;
    @(negedge clk);
    checks++; if (bus.ioctl_wait !== 1'b1 || bus.ram_rd !== 1'b0) begin
      errors++; $display("FAIL abort_in_wait got wait=%b ram_rd=%b exp=1/0", bus.ioctl_wait, bus.ram_rd);
    end
    bus.ioctl_upload = 1'b0;
    @(negedge clk);
    checks++; if (bus.ioctl_wait !== 1'b0) begin errors++; $display("FAIL abort_wait got=%b exp=0", bus.ioctl_wait); end
    repeat (3) @(negedge clk);
    checks++; if (bus.ioctl_din !== din_before) begin errors++; $display("FAIL abort_din got=%h exp=%h", bus.ioctl_din, din_before); end
    bus.ioctl_upload = 1'b1;
    do_read(25'h005, 0, w, r, ok, to);
    checks++; if (to || w != 4 || r != 1) begin
      errors++; $display("FAIL abort_next_read got wait=%0d ram_rd=%0d timeout=%0b exp=4/1/0", w, r, to);
    end
    checks++; if (bus.ioctl_din !== 8'h3C) begin errors++; $display("FAIL abort_next_din got=%h exp=3c", bus.ioctl_din); end
  endtask

  task automatic test_reset_mid();
    bus.core_we = 1'b1;
    @(negedge clk); bus.core_we = 1'b0;
    bus.ram_gnt = 1'b0; bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'h005;
    @(negedge clk); bus.ioctl_rd = 1'b0;
    checks++; if (bus.ram_rd !== 1'b1 || bus.dirty !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got ram_rd=%b dirty=%b exp=1/1", bus.ram_rd, bus.dirty);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.ram_rd !== 1'b0 || bus.ioctl_wait !== 1'b0 || bus.dirty !== 1'b0) begin
      errors++; $display("FAIL rstmid got ram_rd=%b wait=%b dirty=%b exp=0/0/0", bus.ram_rd, bus.ioctl_wait, bus.dirty);
    end
    checks++; if (bus.ioctl_din !== 8'h00 || bus.ram_addr !== 10'h000) begin
      errors++; $display("FAIL rstmid_regs got din=%h addr=%h exp=00/000", bus.ioctl_din, bus.ram_addr);
    end
    reset = 1'b0; bus.ram_gnt = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7);
    mem[5] = 8'h3C; mem[6] = 8'h5A; mem[7] = 8'h77;
    reset = 1'b1;
    bus.ioctl_upload = 1'b0; bus.ioctl_index = 8'd2; bus.ioctl_rd = 1'b0;
    bus.ioctl_addr = '0; bus.save_trigger = 1'b0; bus.core_we = 1'b0; bus.ram_gnt = 1'b1;
    test_reset();
    test_read_basic();
    test_grant_delay();
    test_out_of_range();
    test_wrong_index();
    test_dirty_req();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
